data_mem_responder: RTL and testbench

- Responder end of the core's data-memory request/response interface: the core issues LDR/STR/LDRB/STRB requests, and this block services them.
- Holds a word-addressed RAM and inserts a configurable number of wait states.
- Returns read data plus an error flag through a valid/ready response channel.
- Sits beside the program memory and completes the core's load/store path.

---
 rtl/data_mem_pkg.sv | 22 ++
 rtl/mem_byte_lane.sv | 21 ++
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 tb/tb_data_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and constants for the data-memory responder
package data_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LANE_BITS  = $clog2(WORD_BYTES);
  // Latched addresses are held at this width; ADDR_W must not exceed it.
  localparam int MAX_ADDR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic                  byte_en;
    logic [MAX_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - little-endian byte lane extract and merge
module mem_byte_lane (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [7:0]  byte_o,
  output logic [31:0] merged_o
);

  always_comb begin
    byte_o   = '0;
    merged_o = word_i;
    case (lane_i)
      2'd0: begin byte_o = word_i[7:0];   merged_o[7:0]   = byte_i; end
      2'd1: begin byte_o = word_i[15:8];  merged_o[15:8]  = byte_i; end
      2'd2: begin byte_o = word_i[23:16]; merged_o[23:16] = byte_i; end
      default: begin byte_o = word_i[31:24]; merged_o[31:24] = byte_i; end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM servicing load/store requests with wait states
// Define DATA_MEM_ALIGN_FAULT_EN to make misaligned word accesses fault.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic              req_byte_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_error_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

`ifdef DATA_MEM_ALIGN_FAULT_EN
  localparam bit ALIGN_FAULT = 1'b1;
`else
  localparam bit ALIGN_FAULT = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q, req_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_error_q, rsp_error_d;

  logic [31:0]      mem [DEPTH];

  mem_req_t         live_req, cur;
  logic [IDX_W-1:0] mem_idx;
  logic [1:0]       lane;
  logic             in_range, misaligned, fault, resp_fire;
  logic [31:0]      rd_word, merged_word, wr_word, rd_data;
  logic [7:0]       lane_byte;

  always_comb begin
    live_req         = '0;
    live_req.write   = req_write_i;
    live_req.byte_en = req_byte_i;
    live_req.addr    = MAX_ADDR_W'(req_addr_i);
    live_req.wdata   = req_wdata_i;
  end

  // With no wait states the response edge is the accept edge, so decode the live request.
  assign cur        = (state_q == S_IDLE) ? live_req : req_q;
  assign lane       = cur.addr[LANE_BITS-1:0];
  assign mem_idx    = cur.addr[IDX_W+LANE_BITS-1:LANE_BITS];
  assign in_range   = 32'(cur.addr[MAX_ADDR_W-1:LANE_BITS]) < 32'(DEPTH);
  assign misaligned = !cur.byte_en && (lane != 2'd0);
  assign fault      = !in_range || (ALIGN_FAULT && misaligned);
  assign rd_word    = mem[mem_idx];

  mem_byte_lane u_lane (
    .word_i   (rd_word),
    .lane_i   (lane),
    .byte_i   (cur.wdata[7:0]),
    .byte_o   (lane_byte),
    .merged_o (merged_word)
  );

  assign wr_word = cur.byte_en ? merged_word : cur.wdata;
  assign rd_data = cur.byte_en ? {24'd0, lane_byte} : rd_word;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    resp_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          req_d = live_req;
          cnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            resp_fire = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          resp_fire = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
        end
      end
    endcase
    if (resp_fire) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = fault;
      rsp_rdata_d = (fault || cur.write) ? 32'd0 : rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // RAM is never reset; a reset on the response edge also blocks the store.
  always_ff @(posedge clk) begin
    if (reset_ni && resp_fire && !fault && cur.write) begin
      mem[mem_idx] <= wr_word;
    end
  end

  assign req_ready_o = (state_q == S_IDLE) && reset_ni;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
// Build with DATA_MEM_ALIGN_FAULT_EN to match an align-fault RTL build.
module tb_data_mem_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int ADDR_W      = 9;

  logic              clk = 1'b0;
  logic              reset_ni = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_write_i = 1'b0;
  logic              req_byte_i = 1'b0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic [31:0]       req_wdata_i = '0;
  logic              rsp_ready_i = 1'b1;
  logic              req_ready_o, rsp_valid_o, rsp_error_o;
  logic [31:0]       rsp_rdata_o;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH       (64),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_ni    (reset_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_byte_i  (req_byte_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset_ni && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e[31:0]);
        chk("rsp_error", 32'(rsp_error_o), 32'(e[32]));
      end
    end
  end

  // Called just after a rising edge; scrambles req_* after accept to prove they are latched.
  task automatic do_req(input logic wr, input logic by, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit wait_done);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_before_accept", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_byte_i  = by;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_write_i = ~wr;
    req_byte_i  = ~by;
    req_addr_i  = ~addr;
    req_wdata_i = 32'h5A5A_5A5A;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!rsp_valid_o && n < 50);
    chk("rsp_latency", 32'(n), 32'(WAIT_CYCLES + 1));
    if (wait_done) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (rsp_valid_o && n < 50);
      chk("rsp_drained", 32'(rsp_valid_o), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_rsp_error", 32'(rsp_error_o), 32'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;

    // word store and load
    do_req(1'b1, 1'b0, 9'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // byte lanes
    do_req(1'b1, 1'b0, 9'h008, 32'h1122_3344, 32'h0, 1'b0, 1'b1);
    do_req(1'b1, 1'b1, 9'h009, 32'hFFFF_FFAA, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h008, 32'h0, 32'h1122_AA44, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 9'h00B, 32'h0, 32'h0000_0011, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 9'h009, 32'h0, 32'h0000_00AA, 1'b0, 1'b1);

    // out-of-range and last valid word
    do_req(1'b1, 1'b0, 9'h000, 32'h5566_7788, 32'h0, 1'b0, 1'b1);
    do_req(1'b1, 1'b0, 9'h100, 32'h9999_9999, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 1'b0, 9'h100, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 1'b1, 9'h1FF, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 1'b0, 9'h000, 32'h0, 32'h5566_7788, 1'b0, 1'b1);
    do_req(1'b1, 1'b0, 9'h0FC, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h0FC, 32'h0, 32'h0F0F_0F0F, 1'b0, 1'b1);

    // alignment
    do_req(1'b1, 1'b0, 9'h004, 32'h0404_0404, 32'h0, 1'b0, 1'b1);
`ifdef DATA_MEM_ALIGN_FAULT_EN
    do_req(1'b1, 1'b0, 9'h006, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 1'b0, 9'h004, 32'h0, 32'h0404_0404, 1'b0, 1'b1);
    do_req(1'b1, 1'b1, 9'h006, 32'h0000_0077, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h004, 32'h0, 32'h0477_0404, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h007, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    do_req(1'b1, 1'b0, 9'h006, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h004, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
    do_req(1'b1, 1'b1, 9'h006, 32'h0000_0077, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h004, 32'h0, 32'h0B77_F00D, 1'b0, 1'b1);
    do_req(1'b0, 1'b0, 9'h007, 32'h0, 32'h0B77_F00D, 1'b0, 1'b1);
`endif

    // response back-pressure
    rsp_ready_i = 1'b0;
    do_req(1'b0, 1'b0, 9'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
      chk("hold_rsp_error", 32'(rsp_error_o), 32'd0);
      chk("hold_req_ready", 32'(req_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready_o), 32'd1);
    chk("release_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;

    // reset during WAIT discards the store
    do_req(1'b1, 1'b0, 9'h020, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_byte_i  = 1'b0;
    req_addr_i  = 9'h020;
    req_wdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("wait_req_ready", 32'(req_ready_o), 32'd0);
    chk("wait_rsp_valid", 32'(rsp_valid_o), 32'd0);
    reset_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_req_ready", 32'(req_ready_o), 32'd0);
    chk("midreset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("midreset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("midreset_rsp_error", 32'(rsp_error_o), 32'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    do_req(1'b0, 1'b0, 9'h020, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
